// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the arbitrated APB master.
package apb_arb_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NREQ_DEFAULT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant and a registered priority pointer.
module apb_rr_arb
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            found;

    // Search from the pointer upward first, then wrap to the indices below it.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req_i[j] && (IdxW'(j) >= ptr_q)) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req_i[j] && (IdxW'(j) < ptr_q)) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (idx_o == IdxW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ           = NREQ_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSEL1,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int unsigned IdxW = $clog2(NREQ);

    apb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]     grant;
    logic [IdxW-1:0]     win_idx;
    logic                accept;
    logic                tmo_hit;

    apb_rr_arb #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_arb (
        .clk      (clk),
        .rst      (PRESET),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (grant),
        .idx_o    (win_idx)
    );

    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign accept    = |req_ready;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    // Counts ACCESS cycles already spent with PREADY low.
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    assign tmo_hit = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == StSetup) begin
            wait_cnt_d = '0;
        end else if (state_q == StAccess && !PREADY) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        owner_d     = owner_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StSetup;
                    paddr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
                    pwdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
                    pwrite_d = req_write[win_idx];
                    owner_d  = win_idx;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    state_d     = StIdle;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if (tmo_hit) begin
                    state_d     = StIdle;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Control strobes decode straight from the state register so reset clears them at once.
    assign PSEL1     = (state_q != StIdle);
    assign PENABLE   = (state_q == StAccess);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Scoreboard bench for apb_arb_master: timing-level model of grants, APB phases and responses.
module tb_apb_arb_master;

    localparam int NREQ = 2;
    localparam int TMO  = 4;

    logic                 clk = 1'b0;
    logic                 PRESET;
    logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*32-1:0]   req_addr, req_wdata;
    logic [31:0]          rsp_rdata, PADDR, PWDATA, PRDATA;
    logic                 rsp_err, PSEL1, PENABLE, PWRITE, PREADY, PSLVERR;

    always #5 clk = ~clk;

    apb_arb_master #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    typedef struct {
        int          owner;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        err;
        int          waits;
        int          span;
        int          acc;
    } xfer_t;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    xfer_t apb_q[$];
    rsp_t  rsp_q[$];
    int    grant_log[$];

    logic        p_write [NREQ];
    logic [31:0] p_addr  [NREQ];
    logic [31:0] p_wdata [NREQ];
    logic [31:0] p_prdata[NREQ];
    logic        p_err   [NREQ];
    int          p_waits [NREQ];
    bit          acc_flag[NREQ];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ptr = 0;
    int idle_cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first asserted requester scanning upward from the priority pointer.
    function automatic logic [NREQ-1:0] rr_pick(logic [NREQ-1:0] v, int p);
        logic [NREQ-1:0] g = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (g == '0 && v[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
        end
        return g;
    endfunction

    // Monitor / scoreboard, sampling on the falling edge.
    xfer_t           mon_x;
    rsp_t            mon_r;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_sel, exp_en;
    int              win;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (PRESET) begin
                apb_q.delete();
                rsp_q.delete();
                ptr      = 0;
                idle_cyc = 0;
                chk("rst_psel", 32'(PSEL1), 32'd0);
                chk("rst_penable", 32'(PENABLE), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                exp_sel = 1'b0;
                exp_en  = 1'b0;
                if (apb_q.size() > 0) begin
                    mon_x   = apb_q[0];
                    exp_sel = (cyc >= mon_x.acc + 1);
                    exp_en  = (cyc >= mon_x.acc + 2);
                end
                chk("psel", 32'(PSEL1), 32'(exp_sel));
                chk("penable", 32'(PENABLE), 32'(exp_en));
                if (exp_sel) begin
                    chk("paddr", PADDR, mon_x.addr);
                    chk("pwrite", 32'(PWRITE), 32'(mon_x.write));
                    chk("pwdata", PWDATA, mon_x.wdata);
                    if (cyc == mon_x.acc + 2 + mon_x.span) void'(apb_q.pop_front());
                end

                if (rsp_valid != '0 || (rsp_q.size() > 0 && rsp_q[0].due == cyc)) begin
                    if (rsp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
                    end else begin
                        mon_r = rsp_q.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(1) << mon_r.owner);
                        chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                    end
                end

                exp_rdy = (cyc >= idle_cyc) ? rr_pick(req_valid, ptr) : '0;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (exp_rdy != '0) begin
                    for (int k = 0; k < NREQ; k++) if (exp_rdy[k]) win = k;
                    mon_x.owner  = win;
                    mon_x.write  = p_write[win];
                    mon_x.addr   = p_addr[win];
                    mon_x.wdata  = p_wdata[win];
                    mon_x.prdata = p_prdata[win];
                    mon_x.err    = p_err[win];
                    mon_x.waits  = p_waits[win];
                    mon_x.span   = p_waits[win];
                    mon_x.acc    = cyc;
                    mon_r.owner  = win;
                    mon_r.rdata  = p_write[win] ? 32'd0 : p_prdata[win];
                    mon_r.err    = p_err[win];
`ifdef APB_ARB_TIMEOUT_EN
                    if (p_waits[win] >= TMO) begin
                        mon_x.span  = TMO - 1;
                        mon_r.rdata = 32'd0;
                        mon_r.err   = 1'b1;
                    end
`endif
                    mon_r.due = cyc + 3 + mon_x.span;
                    idle_cyc  = mon_r.due;
                    ptr       = (win + 1) % NREQ;
                    apb_q.push_back(mon_x);
                    rsp_q.push_back(mon_r);
                    grant_log.push_back(win);
                    acc_flag[win] = 1'b1;
                end
            end
        end
    end

    // APB completer: inserts the planned wait states, drives junk outside the completion cycle.
    bit          cp_active = 1'b0;
    int          cp_w;
    logic [31:0] cp_rd;
    logic        cp_err;

    initial begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (PRESET) begin
                cp_active = 1'b0;
                PREADY    = 1'b0;
            end else if (PSEL1 && PENABLE) begin
                if (!cp_active) begin
                    cp_active = 1'b1;
                    cp_w      = (apb_q.size() > 0) ? apb_q[0].waits : 0;
                    cp_rd     = (apb_q.size() > 0) ? apb_q[0].prdata : 32'd0;
                    cp_err    = (apb_q.size() > 0) ? apb_q[0].err : 1'b0;
                end
                if (cp_w == 0) begin
                    PREADY  = 1'b1;
                    PRDATA  = cp_rd;
                    PSLVERR = cp_err;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom_range(0, 1));
                    cp_w--;
                end
            end else begin
                cp_active = 1'b0;
                PREADY    = 1'($urandom_range(0, 1));
                PRDATA    = $urandom;
                PSLVERR   = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(int i, logic wr, logic [31:0] addr, logic [31:0] wdata, int waits,
                         logic [31:0] prd, logic err);
        int n = 0;
        p_write[i]  = wr;
        p_addr[i]   = addr;
        p_wdata[i]  = wdata;
        p_prdata[i] = prd;
        p_err[i]    = err;
        p_waits[i]  = waits;
        acc_flag[i] = 1'b0;
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wdata;
        req_valid[i]          = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_flag[i] && n < 200);
        if (!acc_flag[i]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: requester %0d got no grant expected one", i);
        end
        req_valid[i] = 1'b0;
        acc_flag[i]  = 1'b0;
    endtask

    task automatic issue_rand(int i);
        issue(i, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 3)),
              $urandom, 1'($urandom_range(0, 3) == 0));
    endtask

    task automatic drain();
        int n = 0;
        while ((apb_q.size() > 0 || rsp_q.size() > 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(apb_q.size() + rsp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        PRESET = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait write, then a read with three wait states.
        issue(0, 1'b1, 32'h10, 32'hA5A5A5A5, 0, $urandom, 1'b0);
        drain();
        issue(1, 1'b0, 32'h20, $urandom, 3, 32'h12345678, 1'b0);
        drain();

        // Slave error followed by a clean transfer.
        issue(0, 1'b0, $urandom, $urandom, 0, $urandom, 1'b1);
        issue(1, 1'b0, $urandom, $urandom, 0, $urandom, 1'b0);
        drain();

        // Two requesters held busy alternate grants.
        grant_log.delete();
        fork
            begin
                issue_rand(0);
                issue_rand(0);
            end
            begin
                issue_rand(1);
                issue_rand(1);
            end
        join
        drain();
        chk("alt_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("alt_order", 32'(grant_log[k]), 32'(k % 2));
        end

        // Randomized traffic from both requesters.
        fork
            for (int t = 0; t < 25; t++) begin
                issue_rand(0);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int t = 0; t < 25; t++) begin
                issue_rand(1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

`ifdef APB_ARB_TIMEOUT_EN
        issue(1, 1'b0, $urandom, $urandom, 10, 32'hDEADBEEF, 1'b0);
        drain();
        issue(0, 1'b0, $urandom, $urandom, 0, 32'hCAFEF00D, 1'b0);
        drain();
`endif

        // Reset during ACCESS: strobes drop at once, no response, pointer back to 0.
        issue(0, 1'b1, $urandom, $urandom, 6, $urandom, 1'b0);
        @(posedge clk);
        #3;
        PRESET = 1'b1;
        #1;
        chk("async_rst_psel", 32'(PSEL1), 32'd0);
        chk("async_rst_penable", 32'(PENABLE), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        PRESET = 1'b0;
        grant_log.delete();
        fork
            issue_rand(0);
            issue_rand(1);
        join
        drain();
        chk("post_rst_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
